// File: rtl/add_round_key_nb.sv
// rtl/add_round_key_nb.sv - pipelined in-place AddRoundKey over a 4 x nb state array
//
// Purpose:
//   XORs each element of the 4 x nb state array (statemt RAM) with the matching
//   word of round key n (expanded-key word RAM), one element per cycle, writing
//   the result back in place. The block width nb is chosen at runtime, from 1 to
//   NB_MAX columns. Out-of-range values of nb, including 0, select NB_MAX.
//
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   ap_start            start request, sampled in IDLE and DRAIN
//   ap_done, ap_ready   one-cycle pulse while the final write is issued
//   ap_idle             high while the FSM is in IDLE
//   n, nb               round index and column count, latched at start
//   statemt_address0/ce0/q0            state read port, 1-cycle read latency
//   statemt_address1/ce1/we1/d1        state write port
//   word_address0/ce0/q0               key read port, 1-cycle read latency
//
// Element e = 4*j + i, where i is the row and j is the column. The element
// order is column-major. The key word for (i,j) of round n is at address
// i*KEY_STRIDE + n*nb + j.

module add_round_key_nb #(
    parameter int NB_MAX     = 8,
    parameter int DATA_W     = 32,
    parameter int STATE_AW   = 5,
    parameter int WORD_AW    = 9,
    parameter int KEY_STRIDE = 120
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    input  logic [4:0]          n,
    input  logic [3:0]          nb,
    output logic [STATE_AW-1:0] statemt_address0,
    output logic                statemt_ce0,
    input  logic [DATA_W-1:0]   statemt_q0,
    output logic [STATE_AW-1:0] statemt_address1,
    output logic                statemt_ce1,
    output logic                statemt_we1,
    output logic [DATA_W-1:0]   statemt_d1,
    output logic [WORD_AW-1:0]  word_address0,
    output logic                word_ce0,
    input  logic [DATA_W-1:0]   word_q0
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Per-run values derived from n/nb at acceptance. Only their products are
    // needed after the start, so the raw inputs are not kept.
    logic [STATE_AW-1:0] r_e;          // element currently being read
    logic [STATE_AW-1:0] r_last_e;     // 4*nb_l - 1
    logic [WORD_AW-1:0]  r_key_base;   // n_l * nb_l

    // Single write-stage pipeline register: the read issued last cycle.
    logic                r_wr_valid;
    logic [STATE_AW-1:0] r_e_d1;

    logic [3:0]          w_nb_eff;
    logic [5:0]          w_elems;
    logic [STATE_AW-1:0] w_last_e;
    logic [WORD_AW-1:0]  w_key_base;
    logic                w_accept;
    logic                w_last_rd;
    logic [WORD_AW-1:0]  w_row_off;
    logic [WORD_AW-1:0]  w_col;
    logic [WORD_AW-1:0]  w_word_addr;

    // ------------------------------------------------------------------
    // Start-time parameter derivation
    // ------------------------------------------------------------------
    always_comb begin
        if ((nb == 4'd0) || (nb > 4'(NB_MAX))) begin
            w_nb_eff = 4'(NB_MAX);
        end else begin
            w_nb_eff = nb;
        end
        w_elems    = {w_nb_eff, 2'b00};
        w_last_e   = STATE_AW'(w_elems - 6'd1);
        w_key_base = WORD_AW'(n) * WORD_AW'(w_nb_eff);
    end

    // A start is honoured in IDLE and also in DRAIN, so that runs can be
    // issued back to back without an IDLE bubble. A start in RUN is ignored.
    assign w_accept  = ap_start && ((r_state == S_IDLE) || (r_state == S_DRAIN));
    assign w_last_rd = (r_state == S_RUN) && (r_e == r_last_e);

    // ------------------------------------------------------------------
    // Key address for the element being read: row offset + round base + column
    // ------------------------------------------------------------------
    always_comb begin
        case (r_e[1:0])
            2'd0:    w_row_off = '0;
            2'd1:    w_row_off = WORD_AW'(KEY_STRIDE);
            2'd2:    w_row_off = WORD_AW'(2 * KEY_STRIDE);
            default: w_row_off = WORD_AW'(3 * KEY_STRIDE);
        endcase
        w_col       = WORD_AW'(r_e[STATE_AW-1:2]);
        w_word_addr = w_row_off + r_key_base + w_col;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_rd) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ap_start) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Inactive addresses and data are forced to 0, not X.
    // ------------------------------------------------------------------
    always_comb begin
        ap_idle          = (r_state == S_IDLE);
        ap_done          = (r_state == S_DRAIN);
        ap_ready         = (r_state == S_DRAIN);

        statemt_ce0      = 1'b0;
        statemt_address0 = '0;
        word_ce0         = 1'b0;
        word_address0    = '0;
        if (r_state == S_RUN) begin
            statemt_ce0      = 1'b1;
            statemt_address0 = r_e;
            word_ce0         = 1'b1;
            word_address0    = w_word_addr;
        end

        // The write of e overlaps the read of e+1. The addresses always
        // differ, so the write needs no forwarding.
        statemt_ce1      = r_wr_valid;
        statemt_we1      = r_wr_valid;
        statemt_address1 = '0;
        statemt_d1       = '0;
        if (r_wr_valid) begin
            statemt_address1 = r_e_d1;
            statemt_d1       = statemt_q0 ^ word_q0;
        end
    end

    // ------------------------------------------------------------------
    // Element counter, per-run values and the write-stage register
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_e        <= '0;
            r_last_e   <= '0;
            r_key_base <= '0;
            r_wr_valid <= 1'b0;
            r_e_d1     <= '0;
        end else begin
            // Every RUN cycle issues a read, and that read is written back
            // on the following cycle.
            r_wr_valid <= (r_state == S_RUN);
            if (r_state == S_RUN) begin
                r_e_d1 <= r_e;
            end else begin
                r_e_d1 <= '0;
            end

            if (w_accept) begin
                r_e        <= '0;
                r_last_e   <= w_last_e;
                r_key_base <= w_key_base;
            end else if (r_state == S_RUN) begin
                if (w_last_rd) begin
                    r_e <= '0;
                end else begin
                    r_e <= r_e + STATE_AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_add_round_key_nb.sv
// tb/tb_add_round_key_nb.sv - directed self-checking bench for add_round_key_nb

module tb_add_round_key_nb;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [4:0]  n;
    logic [3:0]  nb;
    logic [4:0]  statemt_address0;
    logic        statemt_ce0;
    logic [31:0] statemt_q0;
    logic [4:0]  statemt_address1;
    logic        statemt_ce1;
    logic        statemt_we1;
    logic [31:0] statemt_d1;
    logic [8:0]  word_address0;
    logic        word_ce0;
    logic [31:0] word_q0;

    add_round_key_nb dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .n                (n),
        .nb               (nb),
        .statemt_address0 (statemt_address0),
        .statemt_ce0      (statemt_ce0),
        .statemt_q0       (statemt_q0),
        .statemt_address1 (statemt_address1),
        .statemt_ce1      (statemt_ce1),
        .statemt_we1      (statemt_we1),
        .statemt_d1       (statemt_d1),
        .word_address0    (word_address0),
        .word_ce0         (word_ce0),
        .word_q0          (word_q0)
    );

    always #5 ap_clk = ~ap_clk;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] smem [0:31];
    logic [31:0] kmem [0:511];
    logic        load_req = 1'b0;

    logic        c_ce0, c_ce1, c_we1, c_kce;
    logic [4:0]  c_a0, c_a1;
    logic [31:0] c_d1;
    logic [8:0]  c_ka;

    int          wr_total = 0, rd_total = 0, done_total = 0, idle_total = 0;
    int          idle_active = 0, rdy_diff = 0;
    int          wr_cyc [0:1023];
    int          rd_cyc [0:1023];
    logic [8:0]  rd_wa  [0:1023];
    logic [4:0]  rd_sa  [0:1023];
    int          done_cyc [0:63];

    // Sample the DUT on the falling edge; the RAM models act on the rising edge.
    always @(negedge ap_clk) begin
        c_ce0 <= statemt_ce0;
        c_a0  <= statemt_address0;
        c_ce1 <= statemt_ce1;
        c_we1 <= statemt_we1;
        c_a1  <= statemt_address1;
        c_d1  <= statemt_d1;
        c_kce <= word_ce0;
        c_ka  <= word_address0;
        if (statemt_ce1 && statemt_we1) begin
            wr_cyc[wr_total] <= cyc;
            wr_total         <= wr_total + 1;
        end
        if (word_ce0) begin
            rd_wa[rd_total]  <= word_address0;
            rd_sa[rd_total]  <= statemt_address0;
            rd_cyc[rd_total] <= cyc;
            rd_total         <= rd_total + 1;
        end
        if (ap_done === 1'b1) begin
            done_cyc[done_total] <= cyc;
            done_total           <= done_total + 1;
        end
        if (ap_idle === 1'b1) idle_total <= idle_total + 1;
        if (ap_idle && (statemt_ce0 || statemt_ce1 || statemt_we1 || word_ce0))
            idle_active <= idle_active + 1;
        if (ap_done !== ap_ready) rdy_diff <= rdy_diff + 1;
    end

    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (c_ce0) statemt_q0 <= smem[c_a0];
        if (c_kce) word_q0 <= kmem[c_ka];
        if (load_req) begin
            for (int k = 0; k < 32; k++) smem[k] <= 32'(k);
        end else if (c_ce1 && c_we1) begin
            smem[c_a1] <= c_d1;
        end
    end

    function automatic logic [31:0] key_of(input int i, input int col);
        return 32'(256 * i + col);
    endfunction

    function automatic logic [31:0] exp_elem(input int e, input int rn, input int nbe);
        return 32'(e) ^ key_of(e % 4, rn * nbe + e / 4);
    endfunction

    task automatic tick();
        @(negedge ap_clk);
        #1;
    endtask

    task automatic load_state();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        tick();
    endtask

    task automatic wait_dones(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done_total >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (done_total >= target) ok = 1'b1;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        ap_start = 1'b0;
        n = '0;
        nb = '0;
        repeat (3) tick();
        ap_rst = 1'b0;
        tick();
        checks++; if (ap_idle !== 1'b1) begin errs++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        checks++; if (ap_done !== 1'b0 || ap_ready !== 1'b0) begin errs++; $display("FAIL reset_done got=%b/%b exp=0/0", ap_done, ap_ready); end
        checks++; if ({statemt_ce0, statemt_ce1, statemt_we1, word_ce0} !== 4'b0000) begin
            errs++; $display("FAIL reset_ce got=%b exp=0000", {statemt_ce0, statemt_ce1, statemt_we1, word_ce0}); end
        checks++; if (statemt_address0 !== 5'd0 || statemt_address1 !== 5'd0 || word_address0 !== 9'd0 || statemt_d1 !== 32'd0) begin
            errs++; $display("FAIL reset_addr got=%h/%h/%h/%h exp=0", statemt_address0, statemt_address1, word_address0, statemt_d1); end
    endtask

    task automatic test_nb4_n0();
        int wb, db, t0;
        bit ok;
        load_state();
        wb = wr_total; db = done_total;
        n = 5'd0; nb = 4'd4; ap_start = 1'b1; t0 = cyc;
        tick();
        ap_start = 1'b0;
        wait_dones(db + 1, 60, ok);
        checks++; if (!ok) begin errs++; $display("FAIL nb4_timeout got=0 dones exp=1"); end
        tick();
        checks++; if (done_cyc[db] - t0 != 17) begin errs++; $display("FAIL nb4_done_cycle got=%0d exp=17", done_cyc[db] - t0); end
        checks++; if (wr_total - wb != 16) begin errs++; $display("FAIL nb4_writes got=%0d exp=16", wr_total - wb); end
        checks++; if (wr_cyc[wb] - t0 != 2 || wr_cyc[wb + 15] - t0 != 17) begin
            errs++; $display("FAIL nb4_write_window got=%0d..%0d exp=2..17", wr_cyc[wb] - t0, wr_cyc[wb + 15] - t0); end
        checks++; if (smem[6] !== 32'h207) begin errs++; $display("FAIL nb4_elem6 got=%h exp=207", smem[6]); end
        for (int e = 0; e < 16; e++) begin
            checks++;
            if (smem[e] !== exp_elem(e, 0, 4)) begin errs++; $display("FAIL nb4_data[%0d] got=%h exp=%h", e, smem[e], exp_elem(e, 0, 4)); end
        end
        checks++; if (smem[16] !== 32'd16) begin errs++; $display("FAIL nb4_untouched got=%h exp=10", smem[16]); end
        checks++; if (ap_idle !== 1'b1) begin errs++; $display("FAIL nb4_back_idle got=%b exp=1", ap_idle); end
    endtask

    task automatic test_nb4_n3();
        int rb, db, t0;
        bit ok;
        load_state();
        rb = rd_total; db = done_total;
        n = 5'd3; nb = 4'd4; ap_start = 1'b1; t0 = cyc;
        tick();
        ap_start = 1'b0;
        n = 5'd7; nb = 4'd2;   // must not affect the accepted run
        wait_dones(db + 1, 60, ok);
        checks++; if (!ok) begin errs++; $display("FAIL n3_timeout got=0 dones exp=1"); end
        repeat (4) tick();
        checks++; if (rd_wa[rb] !== 9'd12) begin errs++; $display("FAIL n3_first_key got=%0d exp=12", rd_wa[rb]); end
        checks++; if (rd_wa[rb + 15] !== 9'd375) begin errs++; $display("FAIL n3_r3c3_key got=%0d exp=375", rd_wa[rb + 15]); end
        checks++; if (done_total - db != 1) begin errs++; $display("FAIL n3_done_count got=%0d exp=1", done_total - db); end
        checks++; if (done_cyc[db] - t0 != 17) begin errs++; $display("FAIL n3_done_cycle got=%0d exp=17", done_cyc[db] - t0); end
        checks++; if (smem[0] !== 32'h0000000C) begin errs++; $display("FAIL n3_elem0 got=%h exp=c", smem[0]); end
        for (int e = 0; e < 16; e++) begin
            checks++;
            if (rd_sa[rb + e] !== 5'(e)) begin errs++; $display("FAIL n3_read_order[%0d] got=%0d exp=%0d", e, rd_sa[rb + e], e); end
            checks++;
            if (smem[e] !== exp_elem(e, 3, 4)) begin errs++; $display("FAIL n3_data[%0d] got=%h exp=%h", e, smem[e], exp_elem(e, 3, 4)); end
        end
    endtask

    task automatic test_wide(input logic [3:0] nb_in, input logic [4:0] n_in, input int nbe);
        int wb, rb, db, t0, maxwa;
        bit ok;
        load_state();
        wb = wr_total; rb = rd_total; db = done_total;
        n = n_in; nb = nb_in; ap_start = 1'b1; t0 = cyc;
        tick();
        ap_start = 1'b0;
        wait_dones(db + 1, 100, ok);
        checks++; if (!ok) begin errs++; $display("FAIL wide_nb%0d_timeout got=0 dones exp=1", nb_in); end
        tick();
        maxwa = 0;
        for (int k = rb; k < rd_total; k++) if (int'(rd_wa[k]) > maxwa) maxwa = int'(rd_wa[k]);
        checks++; if (wr_total - wb != 4 * nbe) begin errs++; $display("FAIL wide_nb%0d_writes got=%0d exp=%0d", nb_in, wr_total - wb, 4 * nbe); end
        checks++; if (done_cyc[db] - t0 != 4 * nbe + 1) begin errs++; $display("FAIL wide_nb%0d_done got=%0d exp=%0d", nb_in, done_cyc[db] - t0, 4 * nbe + 1); end
        checks++; if (maxwa != 3 * 120 + int'(n_in) * nbe + nbe - 1) begin
            errs++; $display("FAIL wide_nb%0d_maxaddr got=%0d exp=%0d", nb_in, maxwa, 3 * 120 + int'(n_in) * nbe + nbe - 1); end
        for (int e = 0; e < 4 * nbe; e++) begin
            checks++;
            if (smem[e] !== exp_elem(e, int'(n_in), nbe)) begin
                errs++; $display("FAIL wide_nb%0d_data[%0d] got=%h exp=%h", nb_in, e, smem[e], exp_elem(e, int'(n_in), nbe)); end
        end
    endtask

    task automatic test_nb8_n14();
        test_wide(4'd8, 5'd14, 8);
        checks++; if (smem[31] !== 32'h368) begin errs++; $display("FAIL nb8_elem31 got=%h exp=368", smem[31]); end
    endtask

    task automatic test_clamp();
        test_wide(4'd0, 5'd1, 8);
        test_wide(4'd9, 5'd1, 8);
    endtask

    task automatic test_back_to_back();
        int wb, rb, db, ib;
        bit ok;
        load_state();
        wb = wr_total; rb = rd_total; db = done_total;
        n = 5'd2; nb = 4'd6; ap_start = 1'b1;
        tick();
        ib = idle_total;
        n = 5'd5;              // picked up only when the second run is accepted in DRAIN
        wait_dones(db + 2, 120, ok);
        ap_start = 1'b0;
        checks++; if (!ok) begin errs++; $display("FAIL b2b_timeout got=%0d dones exp=2", done_total - db); end
        checks++; if (idle_total - ib != 0) begin errs++; $display("FAIL b2b_idle_bubble got=%0d exp=0", idle_total - ib); end
        tick();
        checks++; if (done_cyc[db + 1] - done_cyc[db] != 25) begin
            errs++; $display("FAIL b2b_done_gap got=%0d exp=25", done_cyc[db + 1] - done_cyc[db]); end
        checks++; if (rd_cyc[rb + 24] != done_cyc[db] + 1) begin
            errs++; $display("FAIL b2b_second_read got=%0d exp=%0d", rd_cyc[rb + 24], done_cyc[db] + 1); end
        checks++; if (rd_wa[rb] !== 9'd12 || rd_wa[rb + 24] !== 9'd30) begin
            errs++; $display("FAIL b2b_key_base got=%0d/%0d exp=12/30", rd_wa[rb], rd_wa[rb + 24]); end
        checks++; if (wr_total - wb != 48) begin errs++; $display("FAIL b2b_writes got=%0d exp=48", wr_total - wb); end
        for (int e = 0; e < 24; e++) begin
            checks++;
            if (smem[e] !== (exp_elem(e, 2, 6) ^ key_of(e % 4, 30 + e / 4))) begin
                errs++; $display("FAIL b2b_data[%0d] got=%h exp=%h", e, smem[e], exp_elem(e, 2, 6) ^ key_of(e % 4, 30 + e / 4)); end
        end
        repeat (3) tick();
        checks++; if (ap_idle !== 1'b1 || done_total - db != 2) begin
            errs++; $display("FAIL b2b_end got=idle%b dones%0d exp=idle1 dones2", ap_idle, done_total - db); end
    endtask

    task automatic test_reset_mid_run();
        int wb, db, t0;
        bit ok, found;
        load_state();
        wb = wr_total;
        n = 5'd0; nb = 4'd4; ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (statemt_ce0 && statemt_address0 == 5'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!found) begin errs++; $display("FAIL rst_mid_reach_e5 got=0 exp=1"); end
        ap_rst = 1'b1;
        tick();
        checks++; if (ap_idle !== 1'b1) begin errs++; $display("FAIL rst_mid_idle got=%b exp=1", ap_idle); end
        checks++; if ({statemt_ce0, statemt_ce1, statemt_we1, word_ce0} !== 4'b0000) begin
            errs++; $display("FAIL rst_mid_ce got=%b exp=0000", {statemt_ce0, statemt_ce1, statemt_we1, word_ce0}); end
        ap_rst = 1'b0;
        repeat (2) tick();
        checks++; if (wr_total - wb != 5) begin errs++; $display("FAIL rst_mid_writes got=%0d exp=5", wr_total - wb); end
        for (int e = 0; e < 16; e++) begin
            checks++;
            if (smem[e] !== ((e < 5) ? exp_elem(e, 0, 4) : 32'(e))) begin
                errs++; $display("FAIL rst_mid_partial[%0d] got=%h exp=%h", e, smem[e], (e < 5) ? exp_elem(e, 0, 4) : 32'(e)); end
        end
        // A rerun on the partially updated array: elements 0..4 get the key twice.
        db = done_total;
        ap_start = 1'b1; t0 = cyc;
        tick();
        ap_start = 1'b0;
        wait_dones(db + 1, 60, ok);
        checks++; if (!ok) begin errs++; $display("FAIL rst_rerun_timeout got=0 dones exp=1"); end
        tick();
        checks++; if (done_cyc[db] - t0 != 17) begin errs++; $display("FAIL rst_rerun_done got=%0d exp=17", done_cyc[db] - t0); end
        for (int e = 0; e < 16; e++) begin
            checks++;
            if (smem[e] !== ((e < 5) ? 32'(e) : exp_elem(e, 0, 4))) begin
                errs++; $display("FAIL rst_rerun_data[%0d] got=%h exp=%h", e, smem[e], (e < 5) ? 32'(e) : exp_elem(e, 0, 4)); end
        end
    endtask

    task automatic test_global_rules();
        checks++; if (idle_active != 0) begin errs++; $display("FAIL idle_activity got=%0d exp=0", idle_active); end
        checks++; if (rdy_diff != 0) begin errs++; $display("FAIL done_ready_diff got=%0d exp=0", rdy_diff); end
    endtask

    initial begin
        for (int a = 0; a < 512; a++) kmem[a] = 32'hDEAD0000 | 32'(a);
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 120; c++) kmem[i * 120 + c] = key_of(i, c);
        statemt_q0 = '0;
        word_q0    = '0;
        test_reset();
        test_nb4_n0();
        test_nb4_n3();
        test_nb8_n14();
        test_clamp();
        test_back_to_back();
        test_reset_mid_run();
        test_global_rules();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
